pipe_3stage_hs: RTL and testbench

Parametrised, flow-controlled successor of the team's fixed three-stage arithmetic pipeline. It computes F = ((A + B) + (C − D)) × D over N-bit unsigned operands, modulo 2^N. A valid/ready handshake runs on both sides, and each stage stalls independently. It sits between an operand producer and a result consumer that may apply backpressure. A synchronous flush drops all in-flight work.

---
 rtl/pipe_3stage_hs_if.sv | 36 +++
 rtl/pipe_3stage_hs.sv | 88 ++++++++
 tb/tb_pipe_3stage_hs.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_3stage_hs_if.sv
// Handshake/data bundle for pipe_3stage_hs: producer side (in_*, A..D) and consumer side (out_*, F).
// The ovf signal exists only when PIPE_OVF_EN is defined.
interface pipe_3stage_hs_if #(
  parameter int unsigned N = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] F;
`ifdef PIPE_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, A, B, C, D, out_ready,
    input  in_ready, out_valid, F, ovf
  );
  modport slave (
    input  in_valid, A, B, C, D, out_ready,
    output in_ready, out_valid, F, ovf
  );
`else
  modport master (
    output in_valid, A, B, C, D, out_ready,
    input  in_ready, out_valid, F
  );
  modport slave (
    input  in_valid, A, B, C, D, out_ready,
    output in_ready, out_valid, F
  );
`endif
endinterface

// File: rtl/pipe_3stage_hs.sv
// Three-stage F = ((A+B)+(C-D))*D mod 2^N pipeline with valid/ready handshake and per-stage stall.
// Define PIPE_OVF_EN to add the registered overflow flag ovf, aligned with F.
module pipe_3stage_hs #(
  parameter int unsigned N = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_3stage_hs_if.slave io
);
  logic         v1, v2, v3;
  logic         en1, en2, en3;
  logic [N-1:0] x1, x2, d1;
  logic [N-1:0] x3, d2;
  logic [N-1:0] f_q, f_next;

  // A stage may advance when it is empty or the stage after it is advancing.
  assign en3 = !v3 || io.out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;

  assign io.in_ready  = en1;
  assign io.out_valid = v3;
  assign io.F         = f_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= io.in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  // Payload of a stage is don't-care while its valid bit is low, so only stage 3 is reset.
  always_ff @(posedge clk) begin
    if (en1) begin
      x1 <= io.A + io.B;
      x2 <= io.C - io.D;
      d1 <= io.D;
    end
    if (en2) begin
      x3 <= x1 + x2;
      d2 <= d1;
    end
  end

`ifdef PIPE_OVF_EN
  logic           c1, c2;
  logic           fl1, fl2;
  logic           ovf_q;
  logic [2*N-1:0] prod;

  assign c1     = ((io.A + io.B) < io.A) || (io.C < io.D);
  assign c2     = (x1 + x2) < x1;
  assign prod   = {{N{1'b0}}, x3} * {{N{1'b0}}, d2};
  assign f_next = prod[N-1:0];

  always_ff @(posedge clk) begin
    if (en1) fl1 <= c1;
    if (en2) fl2 <= fl1 || c2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en3) begin
      ovf_q <= (|prod[2*N-1:N]) || fl2;
    end
  end

  // Masked so that a flushed entry's stale flag is never visible.
  assign io.ovf = ovf_q && v3;
`else
  assign f_next = x3 * d2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= '0;
    end else if (en3) begin
      f_q <= f_next;
    end
  end
endmodule

// File: tb/tb_pipe_3stage_hs.sv
// Bench for pipe_3stage_hs at N = 10, 4 and 16 driven in lockstep, checked against a queue-based
// model of the formula; honours PIPE_OVF_EN when defined.
module tb_pipe_3stage_hs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] A = '0, B = '0, C = '0, D = '0;
  int unsigned checks = 0;
  int unsigned passes = 0;
  logic        model_on = 1'b0;

  always #5 clk = ~clk;

  pipe_3stage_hs_if #(.N(10)) b10 ();
  pipe_3stage_hs_if #(.N(4))  b4 ();
  pipe_3stage_hs_if #(.N(16)) b16 ();

  assign b10.in_valid = in_valid;   assign b10.out_ready = out_ready;
  assign b10.A = A[9:0];  assign b10.B = B[9:0];  assign b10.C = C[9:0];  assign b10.D = D[9:0];
  assign b4.in_valid = in_valid;    assign b4.out_ready = out_ready;
  assign b4.A = A[3:0];   assign b4.B = B[3:0];   assign b4.C = C[3:0];   assign b4.D = D[3:0];
  assign b16.in_valid = in_valid;   assign b16.out_ready = out_ready;
  assign b16.A = A;       assign b16.B = B;       assign b16.C = C;       assign b16.D = D;

  pipe_3stage_hs #(.N(10)) u10 (.clk(clk), .rst(rst), .flush(flush), .io(b10));
  pipe_3stage_hs #(.N(4))  u4  (.clk(clk), .rst(rst), .flush(flush), .io(b4));
  pipe_3stage_hs #(.N(16)) u16 (.clk(clk), .rst(rst), .flush(flush), .io(b16));

  logic   ir[3], ov[3], of[3];
  longint fv[3];
  assign ir[0] = b10.in_ready;  assign ov[0] = b10.out_valid;  assign fv[0] = longint'(b10.F);
  assign ir[1] = b4.in_ready;   assign ov[1] = b4.out_valid;   assign fv[1] = longint'(b4.F);
  assign ir[2] = b16.in_ready;  assign ov[2] = b16.out_valid;  assign fv[2] = longint'(b16.F);
`ifdef PIPE_OVF_EN
  assign of[0] = b10.ovf;  assign of[1] = b4.ovf;  assign of[2] = b16.ovf;
`else
  assign of[0] = 1'b0;     assign of[1] = 1'b0;    assign of[2] = 1'b0;
`endif

  int unsigned W[3] = '{10, 4, 16};
  longint      q[3][$];

  task automatic check(input string name, input int inst, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s (N=%0d) actual=%0d required=%0d at %0t", name, W[inst], act, exp, $time);
  endtask

  // Result of the formula for width n: bits [n-1:0] = F, bit 32 = overflow (any carry, borrow or high product bit).
  function automatic longint model(input int unsigned n, input logic [15:0] a, b, c, d);
    longint m  = (longint'(1) << n) - 1;
    longint aa = longint'(a) & m, bb = longint'(b) & m, cc = longint'(c) & m, dd = longint'(d) & m;
    longint x1, x2, x3, p;
    bit     o;
    x1 = aa + bb;
    o  = (x1 > m) || (cc < dd);
    x1 = x1 & m;
    x2 = (cc - dd) & m;
    x3 = x1 + x2;
    o  = o || (x3 > m);
    x3 = x3 & m;
    p  = x3 * dd;
    o  = o || ((p >> n) != 0);
    return (p & m) | (longint'(o) << 32);
  endfunction

  // Compare process: outputs are stable at the falling edge; afterwards apply the transfers of the next rising edge.
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        check("in_ready", i, longint'(ir[i]), longint'((q[i].size() < 3) || out_ready));
        if (q[i].size() == 0) begin
          check("out_valid_empty", i, longint'(ov[i]), 0);
        end else if (ov[i]) begin
          check("F", i, fv[i], q[i][0] & 64'hFFFF_FFFF);
`ifdef PIPE_OVF_EN
          check("ovf", i, longint'(of[i]), (q[i][0] >> 32) & 1);
`endif
        end
`ifdef PIPE_OVF_EN
        if (!ov[i]) check("ovf_idle", i, longint'(of[i]), 0);
`endif
        if (rst || flush) begin
          q[i].delete();
        end else begin
          if (ov[i] && out_ready && q[i].size() > 0) void'(q[i].pop_front());
          if (in_valid && ir[i]) q[i].push_back(model(W[i], A, B, C, D));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, b, c, d);
    in_valid = 1'b1;
    A = a; B = b; C = c; D = d;
    step();
  endtask

  task automatic expect10(input string name, input logic v, input longint f);
    check({name, ".valid"}, 0, longint'(b10.out_valid), longint'(v));
    if (v) check({name, ".F"}, 0, longint'(b10.F), f);
  endtask

  task automatic fresh99(input string name);
    send(11, 12, 13, 3);
    expect10({name, "_e0"}, 1'b0, 0);
    in_valid = 1'b0;
    step();
    expect10({name, "_e1"}, 1'b0, 0);
    step();
    expect10({name, "_e2"}, 1'b1, 99);
    step();
  endtask

  int unsigned sent;
  int unsigned cyc;

  initial begin
    rst = 1'b1;
    step();
    model_on = 1'b1;
    step();
    rst = 1'b0;
    check("reset.in_ready", 0, longint'(b10.in_ready), 1);
    check("reset.out_valid", 0, longint'(b10.out_valid), 0);
    check("reset.F", 0, longint'(b10.F), 0);

    // Back-to-back stream, latency E+2
    send(11, 12, 13, 3);
    expect10("b2b_e0", 1'b0, 0);
    send(10, 10, 5, 10);
    expect10("b2b_e1", 1'b0, 0);
    send(2, 2, 2, 4);
    expect10("b2b_r0", 1'b1, 99);
`ifdef PIPE_OVF_EN
    check("b2b_r0.ovf", 0, longint'(b10.ovf), 0);
`endif
    in_valid = 1'b0;
    step();
    expect10("b2b_r1", 1'b1, 150);
    step();
    expect10("b2b_r2", 1'b1, 8);
    step();
    expect10("b2b_end", 1'b0, 0);

    // Wrap cases
    send(1023, 1, 0, 0);
    send(500, 500, 0, 2);
    send(0, 0, 0, 1);
    expect10("wrap0", 1'b1, 0);
    in_valid = 1'b0;
    step();
    expect10("wrap1", 1'b1, 972);
`ifdef PIPE_OVF_EN
    check("wrap1.ovf", 0, longint'(b10.ovf), 1);
`endif
    step();
    expect10("wrap2", 1'b1, 1023);
`ifdef PIPE_OVF_EN
    check("wrap2.ovf", 0, longint'(b10.ovf), 1);
`endif
    step();

    // Backpressure: fill while the consumer stalls
    out_ready = 1'b0;
    send(15, 10, 8, 2);
    send(8, 15, 5, 0);
    send(10, 20, 5, 3);
    in_valid = 1'b1;
    A = 10; B = 10; C = 30; D = 1;
    for (int k = 0; k < 3; k++) begin
      check("bp.in_ready", 0, longint'(b10.in_ready), 0);
      expect10("bp.hold", 1'b1, 62);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 0, longint'(b10.in_ready), 1);
    step();
    in_valid = 1'b0;
    expect10("bp.r1", 1'b1, 0);
    step();
    expect10("bp.r2", 1'b1, 96);
    step();
    expect10("bp.r3", 1'b1, 49);
    step();
    expect10("bp.end", 1'b0, 0);

    // Flush one cycle after acceptance; operand offered during the flush is void
    send(30, 1, 2, 4);
    flush = 1'b1;
    A = 5; B = 5; C = 5; D = 5;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect10("flush.idle", 1'b0, 0);
      step();
    end
    fresh99("flush.fresh");

    // Reset mid-operation
    send(30, 1, 2, 4);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    check("rst.F", 0, longint'(b10.F), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect10("rst.idle", 1'b0, 0);
      step();
    end
    fresh99("rst.fresh");

    // Narrow/wide widths on one operand set
    send(7, 9, 3, 5);
    in_valid = 1'b0;
    step();
    step();
    check("n4.valid", 1, longint'(b4.out_valid), 1);
    check("n4.F", 1, longint'(b4.F), 6);
    check("n16.F", 2, longint'(b16.F), 70);
    step();

    // Random stall/bubble stress
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) begin
        A = 16'($urandom_range(0, 1) * 16'hFFFF);
        D = 16'($urandom_range(0, 2));
      end else begin
        A = 16'($urandom);
        D = 16'($urandom);
      end
      B = 16'($urandom);
      C = 16'($urandom);
      @(negedge clk);
      if (in_valid && b10.in_ready) sent++;
      step();
      cyc++;
    end
    check("rand.sent", 0, longint'(sent), 1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0; k++) step();
    step();
    for (int i = 0; i < 3; i++) check("drain.empty", i, longint'(q[i].size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
